// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: synchronizes the line, validates the start bit, paces
// mid-bit shift strobes for an external 9-bit shift register and buffers frames.
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  input  logic       data_read,
  input  logic [7:0] packet_data,
  input  logic       stop_bit,
  output logic       sr_serial_in,
  output logic       shift_strobe,
  output logic [7:0] rx_data,
  output logic       data_ready,
  output logic       overrun_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] T_HALF_END = TW'(HALF - 1);
  localparam logic [TW-1:0] T_PRE_END  = TW'(CLKS_PER_BIT - 2);
  localparam logic [TW-1:0] T_BIT_END  = TW'(CLKS_PER_BIT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START_CHK = 3'd1;
  localparam logic [2:0] S_RECV      = 3'd2;
  localparam logic [2:0] S_STOP_CHK  = 3'd3;
  localparam logic [2:0] S_LOAD      = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [2:0]    r_state;
  logic [TW-1:0] r_timer;
  logic [3:0]    r_bit_cnt;
  logic          r_shift_strobe;
  logic [7:0]    r_rx_data;
  logic          r_data_ready;
  logic          r_overrun;
  logic          r_framing;

  logic w_fall;
  logic w_load;

  assign w_fall = r_prev & ~r_sync2;
  assign w_load = (r_state == S_LOAD);

  // NOTE: every register here is updated with <= so all reads within a clock
  // see the pre-edge value, matching the flop-to-flop timing of the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= serial_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Strobe is registered one count early so it is high while the timer sits at
  // the last count of the bit, which is where the bit counter advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_timer        <= '0;
      r_bit_cnt      <= 4'd0;
      r_shift_strobe <= 1'b0;
      r_framing      <= 1'b0;
    end else begin
      r_shift_strobe <= (r_state == S_RECV) && (r_timer == T_PRE_END);
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_state <= S_START_CHK;
            r_timer <= '0;
          end
        end
        S_START_CHK: begin
          if (r_timer == T_HALF_END) begin
            if (!r_sync2) begin
              r_framing <= 1'b0;
              r_timer   <= '0;
              r_bit_cnt <= 4'd0;
              r_state   <= S_RECV;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_RECV: begin
          if (r_timer == T_BIT_END) begin
            r_timer   <= '0;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd8) r_state <= S_STOP_CHK;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        S_STOP_CHK: begin
          if (stop_bit) begin
            r_state <= S_LOAD;
          end else begin
            r_framing <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        S_LOAD:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A load in the same cycle as a host read takes priority over the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data    <= 8'h00;
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_load) begin
      r_rx_data    <= packet_data;
      r_data_ready <= 1'b1;
      r_overrun    <= r_data_ready & ~data_read;
    end else if (data_read) begin
      r_data_ready <= 1'b0;
      r_overrun    <= 1'b0;
    end
  end

  assign sr_serial_in  = r_sync2;
  assign shift_strobe  = r_shift_strobe;
  assign rx_data       = r_rx_data;
  assign data_ready    = r_data_ready;
  assign overrun_error = r_overrun;
  assign framing_error = r_framing;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural 9-bit shift register and
// a scoreboard of expected buffer/flag states popped when each frame completes.
module tb_uart_rx_ctrl;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       serial_in;
  logic       data_read;
  logic [7:0] packet_data;
  logic       stop_bit;
  logic       sr_serial_in;
  logic       shift_strobe;
  logic [7:0] rx_data;
  logic       data_ready;
  logic       overrun_error;
  logic       framing_error;
  logic       busy;

  logic [8:0] sr = 9'h000;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .packet_data   (packet_data),
    .stop_bit      (stop_bit),
    .sr_serial_in  (sr_serial_in),
    .shift_strobe  (shift_strobe),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  // Shift register: new bit enters at the top, so after 9 shifts the LSB-first
  // data sits in [7:0] and the stop bit in [8].
  always @(posedge clk) if (shift_strobe) sr <= {sr_serial_in, sr[8:1]};
  assign packet_data = sr[7:0];
  assign stop_bit    = sr[8];

  typedef struct packed {
    logic [7:0] rx;
    logic       rdy;
    logic       ovr;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic [7:0] m_rx;
  logic       m_rdy;
  logic       m_ovr;
  logic       m_fe;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic rst_q = 1'b0;
  always @(posedge clk) rst_q <= rst;

  int cyc = 0;
  int n_strobe = 0;
  int tot_strobe = 0;
  int last_cyc = 0;
  int cd = 0;

  // Frame-completion monitor: buffer is compared three samples after the 9th strobe.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_q) begin
      n_strobe = 0;
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk("sb_pending", 8'(sb.size() > 0), 8'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rx_data", rx_data, e.rx);
            chk("data_ready", 8'(data_ready), 8'(e.rdy));
            chk("overrun_error", 8'(overrun_error), 8'(e.ovr));
            chk("framing_error", 8'(framing_error), 8'(e.fe));
          end
        end
      end
      if (shift_strobe === 1'b1) begin
        tot_strobe++;
        if (n_strobe > 0) chk("strobe_gap", 8'(cyc - last_cyc), 8'(CPB));
        last_cyc = cyc;
        n_strobe++;
        if (n_strobe == 9) begin
          cd = 3;
          n_strobe = 0;
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sr_serial_in"}, 8'(sr_serial_in), 8'd1);
    chk({tag, "_shift_strobe"}, 8'(shift_strobe), 8'd0);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_data_ready"}, 8'(data_ready), 8'd0);
    chk({tag, "_overrun"}, 8'(overrun_error), 8'd0);
    chk({tag, "_framing"}, 8'(framing_error), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
  endtask

  // Drives one frame starting at a negedge; optional read pulse in the LOAD
  // cycle, or a one-cycle reset just after the 4th strobe.
  task automatic send(input logic [7:0] d, input logic stop, input bit rd_load, input bit do_rst);
    logic [9:0] bits;
    int tot0;
    bits = {stop, d, 1'b0};
    tot0 = tot_strobe;
    if (!do_rst) begin
      if (stop) begin
        m_ovr = m_rdy & ~rd_load;
        m_rdy = 1'b1;
        m_rx  = d;
        m_fe  = 1'b0;
      end else begin
        m_fe = 1'b1;
      end
      sb.push_back('{m_rx, m_rdy, m_ovr, m_fe});
    end
    for (int i = 0; i < 100; i++) begin
      if (do_rst && i == 51) begin
        rst = 1'b0;
        chk_reset_outputs("midframe_rst");
        m_rx = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
      end
      if (i == 40) begin
        chk("busy_mid", 8'(busy), 8'd1);
        chk("fe_cleared_at_start", 8'(framing_error), 8'd0);
      end
      serial_in = bits[i / 10];
      data_read = rd_load && (i == 99);
      if (do_rst && i == 50) rst = 1'b1;
      @(negedge clk);
    end
    data_read = 1'b0;
    serial_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("strobe_count", 8'(tot_strobe - tot0), do_rst ? 8'd4 : 8'd9);
    chk("busy_idle", 8'(busy), 8'd0);
  endtask

  task automatic read_pulse();
    data_read = 1'b1;
    @(negedge clk);
    data_read = 1'b0;
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    chk("read_data_ready", 8'(data_ready), 8'(m_rdy));
    chk("read_overrun", 8'(overrun_error), 8'(m_ovr));
    @(negedge clk);
  endtask

  task automatic glitch();
    int tot0;
    int k;
    tot0 = tot_strobe;
    serial_in = 1'b0;
    repeat (3) @(negedge clk);
    serial_in = 1'b1;
    chk("glitch_busy", 8'(busy), 8'd1);
    k = 0;
    while (k < 12 && busy !== 1'b0) begin
      @(negedge clk);
      k++;
    end
    chk("glitch_settle_within_6", 8'(k <= 6), 8'd1);
    repeat (4) @(negedge clk);
    chk("glitch_strobes", 8'(tot_strobe - tot0), 8'd0);
    chk("glitch_rx_data", rx_data, m_rx);
    chk("glitch_data_ready", 8'(data_ready), 8'(m_rdy));
    chk("glitch_overrun", 8'(overrun_error), 8'(m_ovr));
    chk("glitch_framing", 8'(framing_error), 8'(m_fe));
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    data_read = 1'b0;
    m_rx = 8'h00; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'h3C, 1'b0, 1'b0, 1'b0);
    send(8'h11, 1'b1, 1'b0, 1'b0);
    read_pulse();
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    read_pulse();
    glitch();
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    read_pulse();
    send(8'hFF, 1'b1, 1'b0, 1'b1);
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    send(8'h77, 1'b1, 1'b1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
    chk("no_partial_frame", 8'(n_strobe), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
